// File: rtl/carfield_addr_map_unit.sv
// carfield_addr_map_unit
//
// Runtime-programmable address map placed in front of the crossbar routing
// logic. Each of NumRegions entries holds base/size/enable/lock. Entries
// start from the RstBase/RstSize/RstEnable parameters, can be rewritten
// over a small register port, and become read-only once locked. A single
// output register holds the decode of each accepted request address: the
// lowest hitting region index, or NumRegions on a miss.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i
//                          register access (always accepted)
//   cfg_rvalid_o/rdata_o/err_o
//                          response, one cycle after every cfg_req_i
//   req_valid_i/ready_o/addr_i
//                          decode request
//   rsp_valid_o/ready_i/idx_o/hit_o/multi_o
//                          decode result
//
// Register map
//   0x20*r + 0x00/0x04     BASE_LO / BASE_HI of region r
//   0x20*r + 0x08/0x0C     SIZE_LO / SIZE_HI of region r
//   0x20*r + 0x10          CTRL: bit0 enable, bit1 lock
//   0xF00                  MISS_CNT (16-bit saturating, any write clears)
//   0xF04                  STATUS: bit0 sticky locked-write error, W1C
//   0xF08                  NUM_REGIONS (read-only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready_o = !rsp_valid_o || rsp_ready_i, so the output
// register accepts a new request whenever it is empty or being drained in
// the same cycle. rsp_* stay stable while rsp_valid_o && !rsp_ready_i.

module carfield_addr_map_unit #(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 64,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RstBase = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RstSize = '0,
  parameter logic [NumRegions-1:0]                RstEnable = '0,
  parameter int unsigned IdxWidth = $clog2(NumRegions + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [11:0]          cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic                 rsp_hit_o,
  output logic                 rsp_multi_o
);

  localparam int unsigned HiWidth  = AddrWidth - 32;
  localparam int unsigned SelWidth = (NumRegions > 1) ? $clog2(NumRegions) : 1;

  // Region table
  logic [NumRegions-1:0][AddrWidth-1:0] base_q;
  logic [NumRegions-1:0][AddrWidth-1:0] size_q;
  logic [NumRegions-1:0]                en_q;
  logic [NumRegions-1:0]                lock_q;

  logic [15:0] miss_cnt_q;
  logic        status_q;

  // ------------------------------------------------------------------
  // Config address decode
  // ------------------------------------------------------------------
  logic [6:0]          reg_sel;
  logic [2:0]          reg_off;
  logic [SelWidth-1:0] ridx;
  logic                is_global;
  logic                region_ok;

  assign reg_sel   = cfg_addr_i[11:5];
  assign reg_off   = cfg_addr_i[4:2];
  assign ridx      = reg_sel[SelWidth-1:0];
  assign is_global = (cfg_addr_i[11:8] == 4'hF);
  assign region_ok = (32'(reg_sel) < NumRegions);

  logic [31:0] rdata_d;
  logic        err_d;
  logic        wr_base_lo, wr_base_hi, wr_size_lo, wr_size_hi, wr_ctrl;
  logic        miss_clr, status_clr, status_set;

  always_comb begin
    rdata_d    = '0;
    err_d      = 1'b0;
    wr_base_lo = 1'b0;
    wr_base_hi = 1'b0;
    wr_size_lo = 1'b0;
    wr_size_hi = 1'b0;
    wr_ctrl    = 1'b0;
    miss_clr   = 1'b0;
    status_clr = 1'b0;
    status_set = 1'b0;
    if (cfg_req_i) begin
      if (cfg_addr_i[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else if (is_global) begin
        case (cfg_addr_i[7:0])
          8'h00: if (cfg_we_i) miss_clr = 1'b1;
                 else rdata_d = {16'h0, miss_cnt_q};
          8'h04: if (cfg_we_i) status_clr = cfg_wdata_i[0];
                 else rdata_d = {31'h0, status_q};
          8'h08: if (cfg_we_i) err_d = 1'b1;
                 else rdata_d = 32'(NumRegions);
          default: err_d = 1'b1;
        endcase
      end else if (!region_ok) begin
        err_d = 1'b1;
      end else if (cfg_we_i && lock_q[ridx]) begin
        // Locked block: drop the write, flag it and remember it.
        err_d      = 1'b1;
        status_set = 1'b1;
      end else begin
        case (reg_off)
          3'd0: if (cfg_we_i) wr_base_lo = 1'b1;
                else rdata_d = base_q[ridx][31:0];
          3'd1: if (cfg_we_i) wr_base_hi = 1'b1;
                else rdata_d = 32'(base_q[ridx][AddrWidth-1:32]);
          3'd2: if (cfg_we_i) wr_size_lo = 1'b1;
                else rdata_d = size_q[ridx][31:0];
          3'd3: if (cfg_we_i) wr_size_hi = 1'b1;
                else rdata_d = 32'(size_q[ridx][AddrWidth-1:32]);
          3'd4: if (cfg_we_i) wr_ctrl = 1'b1;
                else rdata_d = {30'h0, lock_q[ridx], en_q[ridx]};
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  // Table update. Decodes accepted at this same edge still see the old
  // table because they sample base_q/size_q/en_q before the update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= RstBase;
      size_q <= RstSize;
      en_q   <= RstEnable;
      lock_q <= '0;
    end else begin
      if (wr_base_lo) base_q[ridx][31:0]           <= cfg_wdata_i;
      if (wr_base_hi) base_q[ridx][AddrWidth-1:32] <= cfg_wdata_i[HiWidth-1:0];
      if (wr_size_lo) size_q[ridx][31:0]           <= cfg_wdata_i;
      if (wr_size_hi) size_q[ridx][AddrWidth-1:32] <= cfg_wdata_i[HiWidth-1:0];
      if (wr_ctrl) begin
        en_q[ridx]   <= cfg_wdata_i[0];
        lock_q[ridx] <= cfg_wdata_i[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_rdata_o  <= rdata_d;
      cfg_err_o    <= err_d;
    end
  end

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  logic [NumRegions-1:0] hits;
  logic                  hit_any;
  logic                  hit_multi;
  logic [IdxWidth-1:0]   hit_idx;

  // The subtraction form keeps base+size == 2^AddrWidth legal without a
  // carry bit; size 0 can never satisfy the "<" test.
  always_comb begin
    hits      = '0;
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    hit_idx   = IdxWidth'(NumRegions);
    for (int r = 0; r < int'(NumRegions); r++) begin
      hits[r] = en_q[r] && (req_addr_i >= base_q[r]) &&
                ((req_addr_i - base_q[r]) < size_q[r]);
      if (hits[r]) begin
        if (hit_any) hit_multi = 1'b1;
        else         hit_idx   = IdxWidth'(r);
        hit_any = 1'b1;
      end
    end
  end

  logic accept;

  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_idx_o   <= '0;
      rsp_hit_o   <= 1'b0;
      rsp_multi_o <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_idx_o   <= hit_idx;
      rsp_hit_o   <= hit_any;
      rsp_multi_o <= hit_multi;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // Miss counter: a clear in the same cycle as a miss wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q <= '0;
    end else if (miss_clr) begin
      miss_cnt_q <= '0;
    end else if (accept && !hit_any && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= 1'b0;
    end else if (status_set) begin
      status_q <= 1'b1;
    end else if (status_clr) begin
      status_q <= 1'b0;
    end
  end

endmodule

// File: doc/carfield_addr_map_unit.md
# carfield_addr_map_unit

Runtime-programmable address map that generalises the static compile-time region table: NumRegions base/size/enable entries load reset values from parameters, can be reprogrammed over a register port, and can be locked. A registered decode stage maps each incoming request address to a target index (first hit wins) or to the default/error index. The unit sits in front of the system crossbar's routing logic. It also counts decode misses and flags overlapping hits.

## Interface
Parameters:
- NumRegions, 8, number of programmable regions (1..16)
- AddrWidth, 64, decoded address width (33..64)
- RstBase, all 0, array [NumRegions] of AddrWidth-bit reset base addresses
- RstSize, all 0, array [NumRegions] of AddrWidth-bit reset sizes
- RstEnable, '0, NumRegions-bit reset enable mask
- IdxWidth, $clog2(NumRegions+1), derived; width of the target index

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_req_i  in  1  config access strobe
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  12  byte address, word aligned
- cfg_wdata_i  in  32  write data
- cfg_rvalid_o  out  1  response valid, one cycle after cfg_req_i
- cfg_rdata_o  out  32  read data, qualified by cfg_rvalid_o
- cfg_err_o  out  1  access error, qualified by cfg_rvalid_o
- req_valid_i  in  1  decode request valid
- req_ready_o  out  1  decode request ready
- req_addr_i  in  AddrWidth  address to decode
- rsp_valid_o  out  1  decode result valid
- rsp_ready_i  in  1  decode result accepted
- rsp_idx_o  out  IdxWidth  winning region; NumRegions on miss
- rsp_hit_o  out  1  at least one region hit
- rsp_multi_o  out  1  more than one region hit (overlap)

## Operation
- Region r register block at 0x20·r:
  - +0x00 BASE_LO, +0x04 BASE_HI, +0x08 SIZE_LO, +0x0C SIZE_HI
  - +0x10 CTRL: bit0 enable, bit1 lock
  - HI bits above AddrWidth-32 read 0 and ignore writes.
- Global registers:
  - 0xF00 MISS_CNT: 16-bit saturating miss counter; any write clears it.
  - 0xF04 STATUS: bit0 sticky locked-write error; write 1 clears.
  - 0xF08 NUM_REGIONS: read-only.
- Lock:
  - When lock=1, all writes to that region's block are dropped, cfg_err_o=1 and STATUS.bit0 is set.
  - Lock clears only on reset. Writing lock=1 together with new enable takes effect, then locks.
- Error responses:
  - Unmapped offset or region index ≥ NumRegions: read returns 0, cfg_err_o=1.
  - Write to NUM_REGIONS: cfg_err_o=1.
- Hit rule for region r:
  - enable && req_addr ≥ base && (req_addr − base) < size, computed in AddrWidth-bit unsigned arithmetic.
  - size 0 never hits. base+size may reach 2^AddrWidth, and the subtraction form handles that without overflow.
- Decode result:
  - rsp_idx_o is the lowest hitting index; NumRegions if none hit.
  - rsp_multi_o is set when popcount(hits) ≥ 2.
  - Every accepted miss increments MISS_CNT, saturating at 0xFFFF.
- Simultaneous events:
  - A MISS_CNT write-clear and a miss in the same cycle give MISS_CNT=0; the clear wins.
  - A config write and a decode acceptance in the same cycle: the decode uses the pre-write table.

## Timing
- Reset values:
  - Region table = RstBase/RstSize/RstEnable; all locks 0, MISS_CNT 0, STATUS 0.
  - rsp_valid_o 0, rsp_idx_o 0, rsp_hit_o 0, rsp_multi_o 0, cfg_rvalid_o 0, cfg_rdata_o 0, cfg_err_o 0.
- Config port:
  - Always accepts. cfg_rvalid_o pulses exactly one cycle after each cfg_req_i, including writes.
  - The write updates the table at the clock edge of the request. Decodes accepted on the following cycle see the new value.
- Decode port:
  - One output register. req_ready_o = !rsp_valid_o || rsp_ready_i (full throughput, combinational ready path).
  - Latency: a request accepted at edge N is presented at rsp_valid_o after edge N.
  - rsp_* outputs hold stable while rsp_valid_o && !rsp_ready_i.
- Reset mid-transfer: the pending response is discarded and rsp_valid_o drops asynchronously. The table reverts to reset parameters.

## Test plan
- Reset table: NumRegions=8, RstBase[0]=0x78000000, RstSize[0]=0x200000, RstEnable=1. Decode 0x781FFFFF -> idx 0, hit 1. Decode 0x78200000 -> idx 8, hit 0, MISS_CNT=1.
- Programming: write region 3 base 0x20001000, size 0x9000, enable 1. Next-cycle decode of 0x20009FFF -> idx 3; decode of 0x2000A000 -> miss.
- Overlap: region 1 and region 5 both cover 0x40000000 -> idx 1, multi 1.
- Lock: set region 2 lock=1, then write BASE_LO -> cfg_err_o=1, readback unchanged, STATUS=1. Write STATUS=1 -> STATUS=0.
- Backpressure: stream 4 addresses with rsp_ready_i held low for 3 cycles -> the first result is held stable, req_ready_o=0, and all 4 results arrive in order with none lost.
- Boundaries:
  - base 0xFFFF_FFFF_FFFF_F000 with size 0x1000: address 0xFFFF_FFFF_FFFF_FFFF hits.
  - size 0 never hits.
  - MISS_CNT held at 0xFFFF after 0x10005 misses; a clear in the same cycle as a miss leaves 0.
